// File: rtl/adder_arbiter.sv
// adder_arbiter: two-requester round-robin accumulator.
// A granted requester streams operands (valid/ready, last marks the end of a job);
// the operands are summed modulo 2^WIDTH by a single CLA, and the job result is
// presented with a valid/ready handshake.
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_reqN_valid/data/last, o_reqN_ready  operand streams from requesters 0 and 1
//   o_valid, o_sum, o_id, o_ovf, o_beats  job result (sum, owner, sticky carry, beat count)
//   i_ready                           downstream accepts result

// Carry-lookahead adder: every carry is flattened from generate/propagate terms.
module CLA_nbit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_carry,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
);
    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH:0]   carry;

    assign gen  = i_a & i_b;
    assign prop = i_a ^ i_b;

    // Each carry is expanded directly from the operand bits below it.
    always_comb begin
        logic cc;
        carry = '0;
        carry[0] = i_carry;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cc = i_carry;
            for (int j = 0; j <= i; j++) begin
                cc = gen[j] | (prop[j] & cc);
            end
            carry[i+1] = cc;
        end
    end

    assign o_sum   = prop ^ carry[WIDTH-1:0];
    assign o_carry = carry[WIDTH];
endmodule

module adder_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req0_valid,
    input  logic [WIDTH-1:0] i_req0_data,
    input  logic             i_req0_last,
    output logic             o_req0_ready,
    input  logic             i_req1_valid,
    input  logic [WIDTH-1:0] i_req1_data,
    input  logic             i_req1_last,
    output logic             o_req1_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_id,
    output logic             o_ovf,
    output logic [7:0]       o_beats,
    input  logic             i_ready
);
    localparam int unsigned BEATS_W = 8;
    localparam logic [BEATS_W-1:0] BEATS_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_served_q, last_served_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [BEATS_W-1:0] beats_q, beats_d;
    logic               valid_q, valid_d;
    logic               ready0_q, ready0_d;
    logic               ready1_q, ready1_d;

    logic               g_valid;
    logic               g_last;
    logic [WIDTH-1:0]   g_data;
    logic [WIDTH-1:0]   cla_sum;
    logic               cla_cout;

    // Granted requester's stream; the other side is never looked at.
    assign g_valid = grant_q ? i_req1_valid : i_req0_valid;
    assign g_last  = grant_q ? i_req1_last  : i_req0_last;
    assign g_data  = grant_q ? i_req1_data  : i_req0_data;

    CLA_nbit #(.WIDTH(WIDTH)) u_cla (
        .i_a     (acc_q),
        .i_b     (g_data),
        .i_carry (1'b0),
        .o_sum   (cla_sum),
        .o_carry (cla_cout)
    );

    // Next-state, arbitration and accumulation.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_served_d = last_served_q;
        acc_d         = acc_q;
        ovf_d         = ovf_q;
        beats_d       = beats_q;

        unique case (state_q)
            IDLE: begin
                if (i_req0_valid || i_req1_valid) begin
                    // Both pending: the side not served last wins.
                    if (i_req0_valid && i_req1_valid) grant_d = ~last_served_q;
                    else                              grant_d = i_req1_valid;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    beats_d = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (g_valid) begin
                    acc_d   = cla_sum;
                    ovf_d   = ovf_q | cla_cout;
                    beats_d = (beats_q == BEATS_MAX) ? BEATS_MAX : beats_q + BEATS_W'(1);
                    if (g_last) state_d = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    last_served_d = grant_q;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake outputs are registered from the next state.
        valid_d  = (state_d == DONE);
        ready0_d = (state_d == ACCUM) && !grant_d;
        ready1_d = (state_d == ACCUM) &&  grant_d;
    end

    // State register; last_served resets to 1 so requester 0 wins first.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= IDLE;
            grant_q       <= 1'b0;
            last_served_q <= 1'b1;
            acc_q         <= '0;
            ovf_q         <= 1'b0;
            beats_q       <= '0;
            valid_q       <= 1'b0;
            ready0_q      <= 1'b0;
            ready1_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_served_q <= last_served_d;
            acc_q         <= acc_d;
            ovf_q         <= ovf_d;
            beats_q       <= beats_d;
            valid_q       <= valid_d;
            ready0_q      <= ready0_d;
            ready1_q      <= ready1_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_sum        = acc_q;
    assign o_id         = grant_q;
    assign o_ovf        = ovf_q;
    assign o_beats      = beats_q;
    assign o_req0_ready = ready0_q;
    assign o_req1_ready = ready1_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed scoreboard bench for adder_arbiter (WIDTH = 32).
module tb_adder_arbiter;
    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         id;
        logic         ovf;
        logic [7:0]   beats;
    } res_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         r0_valid, r0_last, r0_ready;
    logic [W-1:0] r0_data;
    logic         r1_valid, r1_last, r1_ready;
    logic [W-1:0] r1_data;
    logic         valid, id, ovf, ready;
    logic [W-1:0] sum;
    logic [7:0]   beats;

    res_t sb[$];
    int   n_total  = 0;
    int   n_passed = 0;

    logic [W-1:0] m_sum;
    logic         m_ovf;
    logic [7:0]   m_beats;
    logic         m_id;

    always #5 clk = ~clk;

    adder_arbiter #(.WIDTH(W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req0_valid (r0_valid),
        .i_req0_data  (r0_data),
        .i_req0_last  (r0_last),
        .o_req0_ready (r0_ready),
        .i_req1_valid (r1_valid),
        .i_req1_data  (r1_data),
        .i_req1_last  (r1_last),
        .o_req1_ready (r1_ready),
        .o_valid      (valid),
        .o_sum        (sum),
        .o_id         (id),
        .o_ovf        (ovf),
        .o_beats      (beats),
        .i_ready      (ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic start_model(input logic rid);
        m_sum = '0; m_ovf = 1'b0; m_beats = '0; m_id = rid;
    endtask

    task automatic finish_model();
        sb.push_back('{sum: m_sum, id: m_id, ovf: m_ovf, beats: m_beats});
    endtask

    // Present one operand (after `gap` idle cycles) and wait until it is taken.
    task automatic send_beat(input logic rid, input logic [W-1:0] d, input logic lst, input int gap);
        logic acc_ok;
        logic [W:0] wide;
        acc_ok = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        if (rid) begin r1_valid = 1'b1; r1_data = d; r1_last = lst; end
        else     begin r0_valid = 1'b1; r0_data = d; r0_last = lst; end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((rid ? r1_ready : r0_ready) === 1'b1) begin
                acc_ok = 1'b1;
                @(posedge clk); #1;
                break;
            end
        end
        chk("beat_accepted", 64'(acc_ok), 64'd1);
        if (acc_ok) begin
            wide = {1'b0, m_sum} + {1'b0, d};
            m_sum = wide[W-1:0];
            m_ovf = m_ovf | wide[W];
            m_beats = (m_beats == 8'hFF) ? 8'hFF : m_beats + 8'd1;
        end
        if (rid) r1_valid = 1'b0; else r0_valid = 1'b0;
    endtask

    // Wait for a result, compare it to the scoreboard head; optional latency check.
    task automatic collect(input logic lat);
        int   cyc;
        logic seen;
        res_t e;
        seen = 1'b0;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (valid === 1'b1) begin seen = 1'b1; break; end
            cyc++;
        end
        chk("result_seen", 64'(seen), 64'd1);
        if (lat) chk("result_latency", 64'(cyc), 64'd0);
        if (seen && sb.size() > 0) begin
            e = sb.pop_front();
            chk("sum", 64'(sum), 64'(e.sum));
            chk("id", 64'(id), 64'(e.id));
            chk("ovf", 64'(ovf), 64'(e.ovf));
            chk("beats", 64'(beats), 64'(e.beats));
            chk("done_ready0", 64'(r0_ready), 64'd0);
            chk("done_ready1", 64'(r1_ready), 64'd0);
            if (ready === 1'b1) begin
                @(negedge clk);
                chk("valid_low_after_accept", 64'(valid), 64'd0);
            end
        end else if (seen) begin
            chk("scoreboard_nonempty", 64'(sb.size()), 64'd1);
        end
    endtask

    // Both requesters stream single-beat jobs continuously; grants alternate from 0.
    task automatic both_run(input int n, input logic [W-1:0] d0, input logic [W-1:0] d1);
        int   got;
        res_t e;
        got = 0;
        for (int k = 0; k < n; k++)
            sb.push_back('{sum: (k % 2 == 1) ? d1 : d0, id: 1'((k % 2)), ovf: 1'b0, beats: 8'd1});
        r0_valid = 1'b1; r0_data = d0; r0_last = 1'b1;
        r1_valid = 1'b1; r1_data = d1; r1_last = 1'b1;
        for (int i = 0; i < 20 * n; i++) begin
            @(negedge clk);
            chk("ready_exclusive", 64'(r0_ready & r1_ready), 64'd0);
            if (valid === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                chk("alt_id", 64'(id), 64'(e.id));
                chk("alt_sum", 64'(sum), 64'(e.sum));
                chk("alt_beats", 64'(beats), 64'(e.beats));
                got++;
                if (got == n) break;
            end
        end
        chk("alt_count", 64'(got), 64'(n));
        @(posedge clk); #1;
        r0_valid = 1'b0; r1_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ready = 1'b1;
        r0_valid = 1'b0; r0_data = '0; r0_last = 1'b0;
        r1_valid = 1'b0; r1_data = '0; r1_last = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_beats", 64'(beats), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_id", 64'(id), 64'd0);
        chk("rst_ready0", 64'(r0_ready), 64'd0);
        chk("rst_ready1", 64'(r1_ready), 64'd0);

        // Req0 job 3,5,7
        start_model(1'b0);
        send_beat(1'b0, 32'd3, 1'b0, 1);
        send_beat(1'b0, 32'd5, 1'b0, 0);
        send_beat(1'b0, 32'd7, 1'b1, 0);
        finish_model();
        collect(1'b1);

        // Req1 overflow job
        start_model(1'b1);
        send_beat(1'b1, 32'hFFFF_FFFF, 1'b0, 1);
        send_beat(1'b1, 32'h0000_0002, 1'b1, 0);
        finish_model();
        collect(1'b1);

        // Req0 job with two idle cycles between beats
        start_model(1'b0);
        send_beat(1'b0, 32'h10, 1'b0, 1);
        send_beat(1'b0, 32'h20, 1'b0, 2);
        send_beat(1'b0, 32'h30, 1'b1, 2);
        finish_model();
        collect(1'b1);

        // Beat count saturates at 255
        start_model(1'b1);
        for (int i = 0; i < 260; i++) send_beat(1'b1, 32'd1, (i == 259), 0);
        finish_model();
        collect(1'b1);

        // Alternating grants after reset
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        both_run(4, 32'h11, 32'h22);

        // Downstream stall in DONE; req0 pending must not be granted
        ready = 1'b0;
        start_model(1'b1);
        send_beat(1'b1, 32'd9, 1'b1, 1);
        finish_model();
        collect(1'b1);
        r0_valid = 1'b1; r0_data = 32'd5; r0_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(valid), 64'd1);
            chk("hold_sum", 64'(sum), 64'd9);
            chk("hold_id", 64'(id), 64'd1);
            chk("hold_ready0", 64'(r0_ready), 64'd0);
            chk("hold_ready1", 64'(r1_ready), 64'd0);
        end
        @(posedge clk); #1 ready = 1'b1;
        @(negedge clk);
        chk("release_edge_valid", 64'(valid), 64'd1);
        @(negedge clk);
        chk("release_idle_valid", 64'(valid), 64'd0);
        chk("release_idle_ready0", 64'(r0_ready), 64'd0);
        start_model(1'b0);
        send_beat(1'b0, 32'd5, 1'b1, 0);
        finish_model();
        collect(1'b1);

        // Reset mid-ACCUM after two beats
        start_model(1'b0);
        send_beat(1'b0, 32'd100, 1'b0, 1);
        send_beat(1'b0, 32'd200, 1'b0, 0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 64'(valid), 64'd0);
        chk("midrst_sum", 64'(sum), 64'd0);
        chk("midrst_beats", 64'(beats), 64'd0);
        chk("midrst_ovf", 64'(ovf), 64'd0);
        chk("midrst_id", 64'(id), 64'd0);
        chk("midrst_ready0", 64'(r0_ready), 64'd0);
        chk("midrst_ready1", 64'(r1_ready), 64'd0);
        both_run(1, 32'h40, 32'h50);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end
endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst  input  1  reset, synchronous, active-high.
REQ-004 i_req0_valid  input  1  requester 0 operand valid.
REQ-005 i_req0_data  input  WIDTH  requester 0 operand.
REQ-006 i_req0_last  input  1  requester 0 final operand of job.
REQ-007 o_req0_ready  output  1  requester 0 operand accepted when high with valid.
REQ-008 i_req1_valid, i_req1_data, i_req1_last, o_req1_ready SHALL mirror REQ-004..007 for requester 1.
REQ-009 o_valid  output  1  result valid.
REQ-010 o_sum  output  WIDTH  job sum modulo 2^WIDTH.
REQ-011 o_id  output  1  requester that owns the result.
REQ-012 o_ovf  output  1  sticky: any carry-out occurred during the job.
REQ-013 o_beats  output  8  operands accepted in the job, saturating at 255.
REQ-014 i_ready  input  1  downstream accepts result when high with o_valid.

Function
REQ-015 All additions SHALL use exactly one CLA_nbit instance of width WIDTH, i_carry tied 0, operands {accumulator, granted requester data}.
REQ-016 FSM states SHALL be IDLE, ACCUM, DONE only.
REQ-017 IDLE: both readys 0; if any i_reqN_valid, grant per REQ-018, clear accumulator, ovf, beat count, go ACCUM next cycle.
REQ-018 Arbitration round-robin: single request wins; both requesting -> requester not served last wins; after reset requester 0 has priority.
REQ-019 Arbitration costs exactly one IDLE cycle; no operand is accepted in the granting cycle.
REQ-020 ACCUM: o_reqN_ready = 1 only for granted N, other ready = 0.
REQ-021 Each ACCUM cycle with granted valid high: accumulator <= CLA sum, ovf <= ovf | CLA carry-out, beats <= min(beats+1,255).
REQ-022 Granted valid low in ACCUM: state held, no update; grant never revoked until job completes.
REQ-023 Accepted beat with last=1: go DONE next cycle; o_valid asserted the cycle after the last beat (latency 1).
REQ-024 DONE: o_valid=1; o_sum, o_id, o_ovf, o_beats stable; both readys 0.
REQ-025 DONE with i_ready=1: return to IDLE next cycle, record o_id as last served; o_valid low in that IDLE cycle.
REQ-026 Single-beat job (first beat has last=1) SHALL give o_sum = that operand, o_beats = 1, o_ovf = 0.
REQ-027 Non-granted requester inputs SHALL be ignored; its data is not consumed and it may hold valid indefinitely.
REQ-028 Accumulator wraps modulo 2^WIDTH; carry-out never affects o_sum.

Reset
REQ-029 i_rst high at a rising edge: state IDLE, accumulator 0, o_valid 0, o_sum 0, o_id 0, o_ovf 0, o_beats 0, both readys 0, priority to requester 0.
REQ-030 Reset in ACCUM or DONE SHALL abandon the job with no result produced; reset dominates all other inputs in that cycle.

Verification
REQ-031 Req0 job 3, 5, 7 (last on 7), i_ready=1 -> o_valid one cycle after 7 accepted, o_sum=15, o_id=0, o_beats=3, o_ovf=0.
REQ-032 Req1 job 0xFFFFFFFF, 0x00000002 -> o_sum=0x00000001, o_ovf=1, o_id=1.
REQ-033 Both requesters valid from reset, each single-beat job, continuously -> grants alternate 0,1,0,1; neither ready seen for non-granted side.
REQ-034 Req0 job with valid gaps (valid low 2 cycles between beats) -> same sum as gap-free; no beat double-counted.
REQ-035 i_ready held low 4 cycles in DONE -> o_valid and outputs stable, both readys 0, no new grant; release -> IDLE next cycle.
REQ-036 i_rst asserted mid-ACCUM after 2 beats -> next cycle all outputs 0, IDLE; new job afterwards sums from 0, requester 0 prioritised.
